// File: rtl/simple_risc_controller.sv
// Control unit for a small 16-bit RISC datapath: fetches instructions,
// decodes them and sequences the datapath and memory control signals
// through a multi-cycle Moore state machine.
module simple_risc_controller #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mdata,
    input  logic [15:0] datapath_out,
    input  logic [2:0]  Z_out,
    output logic [7:0]  mem_addr,
    output logic [1:0]  mem_cmd,
    output logic [15:0] mem_wdata,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [1:0]  vsel,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [7:0]  PC,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        shift_ctrl,
    output logic        halted
);

    typedef enum logic [4:0] {
        RESET, IF1, IF2, DECODE, WIMM, GETA, GETB, CALC, CMP,
        WREG, ADDR, LDDA, RD1, RD2, STB, STC, WR, HALT
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state;
    state_t      next_state;
    state_t      active_state;
    logic [15:0] ir;
    logic [7:0]  da;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic       is_mem_op;
    logic       calc_uses_zero_a;

    // Status flags are reserved for future branch instructions.
    logic unused_status;
    assign unused_status = ^Z_out;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign sximm8    = {{8{ir[7]}}, ir[7:0]};
    assign sximm5    = {{11{ir[4]}}, ir[4:0]};
    assign mem_wdata = datapath_out;

    assign is_mem_op        = (opcode == 3'b011) || (opcode == 3'b100);
    assign calc_uses_zero_a = (opcode == 3'b110) || (opcode == 3'b101 && op == 2'b11);

    // While rst_n is low the decode is forced to RESET so a write or store
    // that would otherwise land on the reset edge is never presented.
    assign active_state = rst_n ? state : RESET;

    // State register plus the PC, instruction and data-address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET;
            PC    <= RESET_PC;
            ir    <= '0;
            da    <= '0;
        end else begin
            state <= next_state;
            if (state == IF2) begin
                ir <= mdata;
                PC <= PC + 8'd1;
            end
            if (state == LDDA) begin
                da <= datapath_out[7:0];
            end
        end
    end

    // Next-state selection and Moore decode of every control output.
    always_comb begin
        next_state = active_state;
        mem_addr   = PC;
        mem_cmd    = CMD_NONE;
        writenum   = '0;
        readnum    = '0;
        shift      = '0;
        ALUop      = '0;
        vsel       = '0;
        write      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        shift_ctrl = 1'b0;
        halted     = 1'b0;
        case (active_state)
            RESET: next_state = IF1;
            IF1: begin
                mem_cmd    = CMD_READ;
                next_state = IF2;
            end
            IF2: next_state = DECODE;
            DECODE: begin
                case ({opcode, op})
                    5'b110_10: next_state = WIMM;
                    5'b110_00: next_state = GETB;
                    5'b101_11: next_state = GETB;
                    5'b101_00, 5'b101_01, 5'b101_10: next_state = GETA;
                    5'b011_00: next_state = GETA;
                    5'b100_00: next_state = GETA;
                    default:   next_state = HALT;
                endcase
            end
            WIMM: begin
                vsel       = 2'b10;
                writenum   = rn;
                write      = 1'b1;
                next_state = IF1;
            end
            GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = is_mem_op ? ADDR : GETB;
            end
            GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = (op == 2'b01) ? CMP : CALC;
            end
            CALC: begin
                ALUop      = op;
                shift      = ir[4:3];
                asel       = calc_uses_zero_a;
                loadc      = 1'b1;
                next_state = WREG;
            end
            CMP: begin
                ALUop      = op;
                shift      = ir[4:3];
                loads      = 1'b1;
                next_state = IF1;
            end
            WREG: begin
                vsel       = 2'b00;
                writenum   = rd;
                write      = 1'b1;
                next_state = IF1;
            end
            ADDR: begin
                bsel       = 1'b1;
                shift_ctrl = 1'b1;
                loadc      = 1'b1;
                next_state = LDDA;
            end
            LDDA: next_state = (opcode == 3'b011) ? RD1 : STB;
            RD1: begin
                mem_addr   = da;
                mem_cmd    = CMD_READ;
                next_state = RD2;
            end
            RD2: begin
                vsel       = 2'b11;
                writenum   = rd;
                write      = 1'b1;
                next_state = IF1;
            end
            STB: begin
                readnum    = rd;
                loadb      = 1'b1;
                next_state = STC;
            end
            STC: begin
                asel       = 1'b1;
                shift_ctrl = 1'b1;
                loadc      = 1'b1;
                next_state = WR;
            end
            WR: begin
                mem_addr   = da;
                mem_cmd    = CMD_WRITE;
                next_state = IF1;
            end
            HALT: begin
                halted     = 1'b1;
                next_state = HALT;
            end
            default: next_state = RESET;
        endcase
    end

endmodule
